// File: rtl/mm_match_ctrl_pkg.sv
// Shared definitions for the operand-matching controller: token key layout,
// key/match widths and the default operand width.
package mm_match_ctrl_pkg;

  localparam int KEY_W      = 19;
  localparam int MKEY_W     = 18;
  localparam int DW_DEFAULT = 16;

  localparam int COLOR_HI = 18;
  localparam int COLOR_LO = 15;
  localparam int GEN_HI   = 14;
  localparam int GEN_LO   = 11;
  localparam int DEST_HI  = 10;
  localparam int DEST_LO  = 1;
  localparam int LR_BIT   = 0;

  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [MKEY_W-1:0] mkey_t;

  // {color, gen, dest}: the part of a key two partner operands share.
  function automatic mkey_t match_field(input key_t k);
    return {k[COLOR_HI:COLOR_LO], k[GEN_HI:GEN_LO], k[DEST_HI:DEST_LO]};
  endfunction

endpackage

// File: rtl/mm_out_fifo.sv
// Fire-packet FIFO between the matching store and functional-unit dispatch.
// Head fields read as zero while empty so idle outputs are deterministic.
module mm_out_fifo
  import mm_match_ctrl_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CP,
  input  logic                        MR,
  input  logic                        push_i,
  input  mkey_t                       push_key_i,
  input  logic [DW-1:0]               push_ldata_i,
  input  logic [DW-1:0]               push_rdata_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output mkey_t                       key_o,
  output logic [DW-1:0]               ldata_o,
  output logic [DW-1:0]               rdata_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  mkey_t         key_mem [FIFO_DEPTH];
  logic [DW-1:0] l_mem   [FIFO_DEPTH];
  logic [DW-1:0] r_mem   [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Full is the registered state: a pop in the same cycle does not open a slot.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CP) begin
    if (push_ok && !MR) begin
      key_mem[wr_ptr_q] <= push_key_i;
      l_mem[wr_ptr_q]   <= push_ldata_i;
      r_mem[wr_ptr_q]   <= push_rdata_i;
    end
  end

  assign key_o   = empty_o ? '0 : key_mem[rd_ptr_q];
  assign ldata_o = empty_o ? '0 : l_mem[rd_ptr_q];
  assign rdata_o = empty_o ? '0 : r_mem[rd_ptr_q];

endmodule

// File: rtl/mm_match_ctrl.sv
// Operand-matching controller: associative store of unmatched operands; a token
// meeting its opposite-side partner frees the entry and queues a fire packet.
module mm_match_ctrl
  import mm_match_ctrl_pkg::*;
#(
  parameter int NUM_ENTRY  = 8,
  parameter int DW         = DW_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       CP,
  input  logic                       MR,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [KEY_W-1:0]           IN_KEY,
  input  logic [DW-1:0]              IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [MKEY_W-1:0]          OUT_KEY,
  output logic [DW-1:0]              OUT_LDATA,
  output logic [DW-1:0]              OUT_RDATA,
  output logic [$clog2(NUM_ENTRY):0] OCC,
  output logic                       MM_FULL,
  output logic                       DUP
);

  localparam int IW = $clog2(NUM_ENTRY);
  localparam int OW = IW + 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OW-1:0] NUM_C  = OW'(NUM_ENTRY);
  localparam logic [FW-1:0] FDEP_C = FW'(FIFO_DEPTH);

  logic [NUM_ENTRY-1:0] valid_q, valid_d;
  key_t                 key_q  [NUM_ENTRY];
  logic [DW-1:0]        data_q [NUM_ENTRY];
  logic [OW-1:0]        occ_q, occ_d;
  logic                 mm_full_q, mm_full_d;
  logic                 dup_q, dup_d;

  logic [NUM_ENTRY-1:0] hit, same;
  logic                 hit_any, same_any;
  logic [IW-1:0]        hit_idx, free_idx;
  logic                 accept, fire, store;
  logic [DW-1:0]        pkt_l, pkt_r;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FW-1:0]        fifo_count;

  function automatic logic [IW-1:0] lowest_idx(input logic [NUM_ENTRY-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    hit  = '0;
    same = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      hit[i]  = valid_q[i] && (match_field(key_q[i]) == match_field(IN_KEY))
                && (key_q[i][LR_BIT] != IN_KEY[LR_BIT]);
      same[i] = valid_q[i] && (key_q[i] == IN_KEY);
    end
  end

  assign hit_any  = |hit;
  assign same_any = |same;
  assign hit_idx  = lowest_idx(hit);
  assign free_idx = lowest_idx(~valid_q);

  // A hit never needs a free entry, so a full store only stalls unmatched tokens.
  assign IN_READY = !fifo_full && (hit_any || !mm_full_q);
  assign accept   = IN_VALID && IN_READY;
  assign fire     = accept && hit_any;
  assign store    = accept && !hit_any;

  always_comb begin
    pkt_l = IN_DATA;
    pkt_r = data_q[hit_idx];
    if (IN_KEY[LR_BIT]) begin
      pkt_l = data_q[hit_idx];
      pkt_r = IN_DATA;
    end
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    if (fire) begin
      valid_d[hit_idx] = 1'b0;
      occ_d            = occ_q - 1'b1;
    end else if (store) begin
      valid_d[free_idx] = 1'b1;
      occ_d             = occ_q + 1'b1;
    end
    mm_full_d = (occ_d == NUM_C);
    dup_d     = store && same_any;
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      valid_q   <= '0;
      occ_q     <= '0;
      mm_full_q <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      occ_q     <= occ_d;
      mm_full_q <= mm_full_d;
      dup_q     <= dup_d;
    end
  end

  always_ff @(posedge CP) begin
    if (store && !MR) begin
      key_q[free_idx]  <= IN_KEY;
      data_q[free_idx] <= IN_DATA;
    end
  end

  assign OCC     = occ_q;
  assign MM_FULL = mm_full_q;
  assign DUP     = dup_q;

  assign OUT_VALID = !fifo_empty;
  assign fifo_pop  = OUT_VALID && OUT_READY;

  mm_out_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .CP           (CP),
    .MR           (MR),
    .push_i       (fire),
    .push_key_i   (match_field(IN_KEY)),
    .push_ldata_i (pkt_l),
    .push_rdata_i (pkt_r),
    .pop_i        (fifo_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .key_o        (OUT_KEY),
    .ldata_o      (OUT_LDATA),
    .rdata_o      (OUT_RDATA)
  );

  always_ff @(posedge CP) begin
    if (!MR) assert (fifo_full == (fifo_count == FDEP_C));
  end

endmodule

// File: tb/tb_mm_match_ctrl.sv
// Self-checking bench for mm_match_ctrl: vector table, directed corner sequences
// and a randomized run against a slot/queue reference model.
module tb_mm_match_ctrl;

  localparam int NE = 8;
  localparam int FD = 4;

  logic        CP = 1'b0;
  logic        MR;
  logic        IN_VALID;
  logic        IN_READY;
  logic [18:0] IN_KEY;
  logic [15:0] IN_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [17:0] OUT_KEY;
  logic [15:0] OUT_LDATA;
  logic [15:0] OUT_RDATA;
  logic [3:0]  OCC;
  logic        MM_FULL;
  logic        DUP;

  mm_match_ctrl #(.NUM_ENTRY(NE), .DW(16), .FIFO_DEPTH(FD)) dut (
    .CP(CP), .MR(MR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_KEY(IN_KEY), .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_KEY(OUT_KEY), .OUT_LDATA(OUT_LDATA),
    .OUT_RDATA(OUT_RDATA), .OCC(OCC), .MM_FULL(MM_FULL), .DUP(DUP)
  );

  always #5 CP = ~CP;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic do_reset();
    MR       = 1'b1;
    IN_VALID = 1'b0;
    tick();
    MR = 1'b0;
  endtask

  // Present a token, wait (bounded) for IN_READY, let it be accepted.
  task automatic send(input logic [18:0] k, input logic [15:0] d);
    int w;
    IN_VALID = 1'b1;
    IN_KEY   = k;
    IN_DATA  = d;
    #1;
    w = 0;
    while (!IN_READY && w < 50) begin
      tick();
      w++;
    end
    check("send_ready", IN_READY, 1'b1);
    tick();
    IN_VALID = 1'b0;
  endtask

  typedef struct {
    logic [18:0] key;
    logic [15:0] data;
    logic [3:0]  occ;
    logic        ov;
    logic        dup;
    logic [17:0] okey;
    logic [15:0] l;
    logic [15:0] r;
  } vec_t;

  typedef struct {
    logic [17:0] k;
    logic [15:0] l;
    logic [15:0] r;
  } pkt_t;

  vec_t tbl [9];

  logic        m_valid [NE];
  logic [18:0] m_key   [NE];
  logic [15:0] m_data  [NE];
  pkt_t        m_q [$];

  initial begin
    int   hit, free, occ_m;
    logic same_m, exp_ready, acc, pop, dup_m;
    pkt_t p;
    logic [15:0] exp_l [4];
    logic [15:0] exp_r [4];

    MR = 1'b1; IN_VALID = 1'b0; IN_KEY = '0; IN_DATA = '0; OUT_READY = 1'b0;
    tick();
    MR = 1'b0;
    #1;
    check("rst_occ", OCC, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_mm_full", MM_FULL, 0);
    check("rst_dup", DUP, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_out_key", OUT_KEY, 0);
    check("rst_out_ldata", OUT_LDATA, 0);

    // ---------------- vector table: pairs, no-match, duplicate ----------------
    tbl[0] = '{19'h0A246, 16'h1111, 4'd1, 1'b0, 1'b0, 18'h0,    16'h0,    16'h0};
    tbl[1] = '{19'h0A247, 16'h2222, 4'd0, 1'b1, 1'b0, 18'h05123, 16'h1111, 16'h2222};
    tbl[2] = '{19'h0A247, 16'h3333, 4'd1, 1'b0, 1'b0, 18'h0,    16'h0,    16'h0};
    tbl[3] = '{19'h0A246, 16'h4444, 4'd0, 1'b1, 1'b0, 18'h05123, 16'h4444, 16'h3333};
    tbl[4] = '{19'h0A246, 16'h5555, 4'd1, 1'b0, 1'b0, 18'h0,    16'h0,    16'h0};
    tbl[5] = '{19'h12247, 16'h6666, 4'd2, 1'b0, 1'b0, 18'h0,    16'h0,    16'h0};
    tbl[6] = '{19'h0A246, 16'h7777, 4'd3, 1'b0, 1'b1, 18'h0,    16'h0,    16'h0};
    tbl[7] = '{19'h0A247, 16'h8888, 4'd2, 1'b1, 1'b0, 18'h05123, 16'h5555, 16'h8888};
    tbl[8] = '{19'h12246, 16'h9999, 4'd1, 1'b1, 1'b0, 18'h09123, 16'h9999, 16'h6666};

    do_reset();
    OUT_READY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].key, tbl[i].data);
      check($sformatf("vec%0d_occ", i), OCC, tbl[i].occ);
      check($sformatf("vec%0d_dup", i), DUP, tbl[i].dup);
      check($sformatf("vec%0d_out_valid", i), OUT_VALID, tbl[i].ov);
      check($sformatf("vec%0d_out_key", i), OUT_KEY, tbl[i].okey);
      check($sformatf("vec%0d_ldata", i), OUT_LDATA, tbl[i].l);
      check($sformatf("vec%0d_rdata", i), OUT_RDATA, tbl[i].r);
      check($sformatf("vec%0d_mm_full", i), MM_FULL, 0);
    end

    // ---------------- store full / stall / partner of entry 3 ----------------
    do_reset();
    OUT_READY = 1'b0;
    for (int i = 0; i < NE; i++) send(19'((i + 1) * 2), 16'hA000 + 16'(i));
    check("full_occ", OCC, NE);
    check("full_mm_full", MM_FULL, 1);
    IN_VALID = 1'b1; IN_KEY = 19'd40; IN_DATA = 16'hBEEF;
    #1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("full_stall%0d", c), IN_READY, 0);
      tick();
    end
    IN_VALID = 1'b0;
    check("full_stall_occ", OCC, NE);
    check("full_stall_out_valid", OUT_VALID, 0);
    send(19'd9, 16'hC003);
    check("full_hit_occ", OCC, 7);
    check("full_hit_mm_full", MM_FULL, 0);
    check("full_hit_out_valid", OUT_VALID, 1);
    check("full_hit_key", OUT_KEY, 18'd4);
    check("full_hit_ldata", OUT_LDATA, 16'hA003);
    check("full_hit_rdata", OUT_RDATA, 16'hC003);

    // ---------------- backpressure ----------------
    do_reset();
    OUT_READY = 1'b0;
    send(19'd100, 16'h5000);
    for (int p2 = 0; p2 < 4; p2++) begin
      send(19'((p2 + 1) * 2), 16'h1000 + 16'(p2));
      send(19'((p2 + 1) * 2 + 1), 16'h2000 + 16'(p2));
    end
    check("bp_occ", OCC, 1);
    check("bp_head_ldata", OUT_LDATA, 16'h1000);
    IN_VALID = 1'b1; IN_KEY = 19'd101; IN_DATA = 16'h5555;
    #1;
    check("bp_ready_blocked", IN_READY, 0);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("bp_ready_back", IN_READY, 1);
    check("bp_head2_ldata", OUT_LDATA, 16'h1001);
    tick();
    IN_VALID = 1'b0;
    check("bp_occ_after", OCC, 0);
    exp_l = '{16'h1001, 16'h1002, 16'h1003, 16'h5000};
    exp_r = '{16'h2001, 16'h2002, 16'h2003, 16'h5555};
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (!OUT_VALID && w < 20) begin
        tick();
        w++;
      end
      check($sformatf("drain%0d_valid", i), OUT_VALID, 1);
      check($sformatf("drain%0d_ldata", i), OUT_LDATA, exp_l[i]);
      check($sformatf("drain%0d_rdata", i), OUT_RDATA, exp_r[i]);
      tick();
    end
    OUT_READY = 1'b0;
    check("drain_empty", OUT_VALID, 0);

    // ---------------- reset mid-operation ----------------
    do_reset();
    OUT_READY = 1'b0;
    for (int d = 1; d <= 5; d++) send(19'(2 * d), 16'h3000 + 16'(d));
    send(19'd20, 16'h0A0A); send(19'd21, 16'h0B0B);
    send(19'd22, 16'h0C0C); send(19'd23, 16'h0D0D);
    check("mr_pre_occ", OCC, 5);
    check("mr_pre_out_valid", OUT_VALID, 1);
    MR = 1'b1; IN_VALID = 1'b1; IN_KEY = 19'd3; IN_DATA = 16'h4444;
    tick();
    MR = 1'b0; IN_VALID = 1'b0;
    check("mr_occ", OCC, 0);
    check("mr_out_valid", OUT_VALID, 0);
    check("mr_out_key", OUT_KEY, 0);
    check("mr_in_ready", IN_READY, 1);
    check("mr_mm_full", MM_FULL, 0);
    send(19'd3, 16'h4444);
    check("mr_partner_stored_occ", OCC, 1);
    check("mr_partner_no_fire", OUT_VALID, 0);

    // ---------------- randomized run against the reference model ----------------
    do_reset();
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
    m_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      IN_KEY    = {3'b0, 1'($urandom_range(0, 1)), 4'h0, 8'h0,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
      IN_DATA   = 16'($urandom);
      OUT_READY = ($urandom_range(0, 2) == 0);
      #1;
      hit = -1; free = -1; occ_m = 0; same_m = 1'b0;
      for (int i = 0; i < NE; i++) begin
        if (m_valid[i]) begin
          occ_m++;
          if (m_key[i] == IN_KEY) same_m = 1'b1;
          if (hit < 0 && m_key[i][18:1] == IN_KEY[18:1] && m_key[i][0] != IN_KEY[0]) hit = i;
        end else if (free < 0) begin
          free = i;
        end
      end
      exp_ready = (m_q.size() != FD) && (hit >= 0 || occ_m < NE);
      check("rnd_in_ready", IN_READY, exp_ready);
      check("rnd_out_valid", OUT_VALID, m_q.size() != 0);
      if (m_q.size() != 0) p = m_q[0];
      else p = '{18'h0, 16'h0, 16'h0};
      check("rnd_out_key", OUT_KEY, p.k);
      check("rnd_out_ldata", OUT_LDATA, p.l);
      check("rnd_out_rdata", OUT_RDATA, p.r);
      acc   = IN_VALID && exp_ready;
      pop   = (m_q.size() != 0) && OUT_READY;
      dup_m = 1'b0;
      @(posedge CP);
      if (pop) void'(m_q.pop_front());
      if (acc && hit >= 0) begin
        m_valid[hit] = 1'b0;
        if (IN_KEY[0] == 1'b0) m_q.push_back('{IN_KEY[18:1], IN_DATA, m_data[hit]});
        else                   m_q.push_back('{IN_KEY[18:1], m_data[hit], IN_DATA});
      end else if (acc) begin
        dup_m         = same_m;
        m_valid[free] = 1'b1;
        m_key[free]   = IN_KEY;
        m_data[free]  = IN_DATA;
      end
      #1;
      occ_m = 0;
      for (int i = 0; i < NE; i++) if (m_valid[i]) occ_m++;
      check("rnd_occ", OCC, occ_m);
      check("rnd_mm_full", MM_FULL, occ_m == NE);
      check("rnd_dup", DUP, dup_m);
    end
    IN_VALID = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
